// File: rtl/mips_loop_pkg.sv
// Shared types for the hardware loop sequencer: loop-context entry and redirect encodings.
package mips_loop_pkg;

  localparam int unsigned LOOP_ADDR_W = 32;
  localparam int unsigned LOOP_CNT_W  = 6;

  // One nested-loop context; end_pc is the last body instruction (inclusive).
  typedef struct packed {
    logic [LOOP_ADDR_W-1:0] start_pc;
    logic [LOOP_ADDR_W-1:0] end_pc;
    logic [LOOP_CNT_W-1:0]  remain;
    logic [LOOP_ADDR_W-1:0] ret_pc;
  } loop_entry_t;

  typedef enum logic [1:0] {
    REDIRECT_NONE  = 2'd0,
    REDIRECT_START = 2'd1,
    REDIRECT_EXIT  = 2'd2
  } redirect_e;

endpackage

// File: rtl/loop_stack.sv
// DEPTH-entry LIFO of loop contexts.
// Ports: push/push_entry add an entry, pop removes the top, dec_top decrements the
// top remain count, clear empties the stack (highest priority); top/full/empty/count
// report the current state. top reads as all-zero while empty.
module loop_stack
  import mips_loop_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1),
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  loop_entry_t       push_entry,
  input  logic              pop,
  input  logic              dec_top,
  input  logic              clear,
  output loop_entry_t       top,
  output logic              full,
  output logic              empty,
  output logic [OCC_W-1:0]  count
);

  loop_entry_t      mem [DEPTH];
  logic [OCC_W-1:0] count_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign wr_idx  = IDX_W'(count_q);
  assign top_idx = IDX_W'(count_q - OCC_W'(1));
  assign empty   = (count_q == '0);
  assign full    = (count_q == OCC_W'(DEPTH));
  assign top     = empty ? '0 : mem[top_idx];
  assign count   = count_q;

  // Occupancy; clear beats push beats pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + OCC_W'(1);
    end else if (pop && !empty) begin
      count_q <= count_q - OCC_W'(1);
    end
  end

  // Entry storage needs no reset: entries above count are never observed.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push && !full) begin
        mem[wr_idx] <= push_entry;
      end else if (dec_top && !empty && (top.remain != '0)) begin
        mem[top_idx].remain <= top.remain - LOOP_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hw_loop_sequencer.sv
// Zero-overhead loop sequencer: tracks nested loop contexts and redirects fetch
// at loop entry, at each body end (back to start) and at loop exit.
// Ports: loop_start/loop_target/loop_body/loop_iters/loop_ret describe a decoded
// jalfor; pc/pc_valid give the retiring instruction; flush empties the stack;
// err_clr clears sticky errors. redirect/redirect_pc are same-cycle; loop_active,
// loop_depth, cur_remain expose the stack top; err_ovf/err_nest are sticky faults.
module hw_loop_sequencer
  import mips_loop_pkg::*;
#(
  parameter int unsigned ADDR_W      = LOOP_ADDR_W,
  parameter int unsigned CNT_W       = LOOP_CNT_W,
  parameter int unsigned BODY_W      = 6,
  parameter int unsigned DEPTH       = 4,
  parameter bit          EXIT_TO_RET = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       loop_start,
  input  logic [ADDR_W-1:0]          loop_target,
  input  logic [BODY_W-1:0]          loop_body,
  input  logic [CNT_W-1:0]           loop_iters,
  input  logic [ADDR_W-1:0]          loop_ret,
  input  logic [ADDR_W-1:0]          pc,
  input  logic                       pc_valid,
  input  logic                       flush,
  input  logic                       err_clr,
  output logic                       redirect,
  output logic [ADDR_W-1:0]          redirect_pc,
  output logic                       loop_active,
  output logic [$clog2(DEPTH+1)-1:0] loop_depth,
  output logic [CNT_W-1:0]           cur_remain,
  output logic                       err_ovf,
  output logic                       err_nest
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  loop_entry_t       top;
  loop_entry_t       push_entry;
  logic              full;
  logic              empty;
  logic [OCC_W-1:0]  count;
  logic [ADDR_W-1:0] new_end;
  logic [ADDR_W-1:0] zero_exit;
  logic              start_ev;
  logic              end_ev;
  logic              at_end;
  logic              zero_trip;
  logic              misaligned;
  logic              bad_nest;
  logic              do_push;
  logic              do_pop;
  logic              do_dec;
  logic              set_ovf;
  logic              set_nest;
  redirect_e         redirect_kind;
  logic [ADDR_W-1:0] redirect_target;

  // Candidate entry geometry and legality.
  always_comb begin
    new_end    = loop_target + ((ADDR_W'(loop_body) - ADDR_W'(1)) << 2);
    zero_exit  = EXIT_TO_RET ? loop_ret : (loop_target + (ADDR_W'(loop_body) << 2));
    start_ev   = pc_valid && loop_start;
    at_end     = !empty && (pc == top.end_pc);
    end_ev     = pc_valid && !loop_start && at_end;
    zero_trip  = (loop_iters == '0) || (loop_body == '0);
    misaligned = (loop_target[1:0] != 2'b00);
    // Only strictly nested ranges may be pushed on top of an open loop.
    bad_nest   = !empty && ((new_end >= top.end_pc) || (loop_target <= top.start_pc));
    push_entry = '{start_pc: loop_target, end_pc: new_end,
                   remain: loop_iters - CNT_W'(1), ret_pc: loop_ret};
  end

  // Event decode and redirect selection.
  always_comb begin
    do_push         = 1'b0;
    do_pop          = 1'b0;
    do_dec          = 1'b0;
    set_ovf         = 1'b0;
    set_nest        = 1'b0;
    redirect_kind   = REDIRECT_NONE;
    redirect_target = '0;
    if (start_ev) begin
      // A jalfor sitting on the open loop's end PC swallows that end event.
      set_nest = at_end;
      if (zero_trip) begin
        redirect_kind   = REDIRECT_EXIT;
        redirect_target = zero_exit;
      end else if (misaligned || bad_nest) begin
        set_nest = 1'b1;
      end else if (full) begin
        set_ovf = 1'b1;
      end else begin
        do_push         = 1'b1;
        redirect_kind   = REDIRECT_START;
        redirect_target = loop_target;
      end
    end else if (end_ev) begin
      if (top.remain != '0) begin
        do_dec          = 1'b1;
        redirect_kind   = REDIRECT_START;
        redirect_target = top.start_pc;
      end else begin
        do_pop = 1'b1;
        if (EXIT_TO_RET) begin
          redirect_kind   = REDIRECT_EXIT;
          redirect_target = top.ret_pc;
        end
      end
    end
    if (flush) begin
      redirect_kind   = REDIRECT_NONE;
      redirect_target = '0;
    end
  end

  assign redirect    = (redirect_kind != REDIRECT_NONE);
  assign redirect_pc = redirect_target;
  assign loop_active = !empty;
  assign loop_depth  = count;
  assign cur_remain  = top.remain;

  loop_stack #(.DEPTH(DEPTH)) u_stack (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (do_push),
    .push_entry (push_entry),
    .pop        (do_pop),
    .dec_top    (do_dec),
    .clear      (flush),
    .top        (top),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf  <= 1'b0;
      err_nest <= 1'b0;
    end else begin
      if (set_ovf)      err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
      if (set_nest)     err_nest <= 1'b1;
      else if (err_clr) err_nest <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hw_loop_sequencer.sv
// Directed bench for hw_loop_sequencer: dut a (DEPTH 4, exit to ret) and
// dut b (DEPTH 2, fall-through exit) share all inputs.
module tb_hw_loop_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, loop_start, pc_valid, flush, err_clr;
  logic [31:0] loop_target, loop_ret, pc;
  logic [5:0]  loop_body, loop_iters;

  logic        a_redirect, a_active, a_ovf, a_nest;
  logic [31:0] a_rpc;
  logic [2:0]  a_depth;
  logic [5:0]  a_remain;
  logic        b_redirect, b_active, b_ovf, b_nest;
  logic [31:0] b_rpc;
  logic [1:0]  b_depth;
  logic [5:0]  b_remain;

  hw_loop_sequencer #(.DEPTH(4), .EXIT_TO_RET(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .loop_start(loop_start), .loop_target(loop_target),
    .loop_body(loop_body), .loop_iters(loop_iters), .loop_ret(loop_ret), .pc(pc),
    .pc_valid(pc_valid), .flush(flush), .err_clr(err_clr), .redirect(a_redirect),
    .redirect_pc(a_rpc), .loop_active(a_active), .loop_depth(a_depth),
    .cur_remain(a_remain), .err_ovf(a_ovf), .err_nest(a_nest));

  hw_loop_sequencer #(.DEPTH(2), .EXIT_TO_RET(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .loop_start(loop_start), .loop_target(loop_target),
    .loop_body(loop_body), .loop_iters(loop_iters), .loop_ret(loop_ret), .pc(pc),
    .pc_valid(pc_valid), .flush(flush), .err_clr(err_clr), .redirect(b_redirect),
    .redirect_pc(b_rpc), .loop_active(b_active), .loop_depth(b_depth),
    .cur_remain(b_remain), .err_ovf(b_ovf), .err_nest(b_nest));

  typedef struct {
    logic        ls;
    logic [31:0] tgt;
    logic [5:0]  body;
    logic [5:0]  iters;
    logic [31:0] ret;
    logic [31:0] pc;
    logic        pv;
    logic        fl;
    logic        ec;
    logic        e_redir;
    logic [31:0] e_rpc;
    int          e_depth;
    int          e_rem;
    logic        e_ovf;
    logic        e_nest;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic        s_a_redir, s_b_redir;
  logic [31:0] s_a_rpc, s_b_rpc;
  vec_t        tbl[$];

  function automatic vec_t mk(logic ls, logic [31:0] tgt, logic [5:0] body, logic [5:0] iters,
                              logic [31:0] ret, logic [31:0] p, logic pv, logic fl, logic ec,
                              logic er, logic [31:0] erpc, int ed, int erem, logic eovf, logic enest);
    vec_t v;
    v.ls = ls; v.tgt = tgt; v.body = body; v.iters = iters; v.ret = ret; v.pc = p;
    v.pv = pv; v.fl = fl; v.ec = ec; v.e_redir = er; v.e_rpc = erpc; v.e_depth = ed;
    v.e_rem = erem; v.e_ovf = eovf; v.e_nest = enest;
    return v;
  endfunction

  function automatic vec_t jf(logic [31:0] p, logic [31:0] tgt, logic [5:0] body, logic [5:0] iters,
                              logic [31:0] ret, logic er, logic [31:0] erpc, int ed, int erem,
                              logic eovf, logic enest);
    return mk(1'b1, tgt, body, iters, ret, p, 1'b1, 1'b0, 1'b0, er, erpc, ed, erem, eovf, enest);
  endfunction

  function automatic vec_t rt(logic [31:0] p, logic er, logic [31:0] erpc, int ed, int erem,
                              logic eovf, logic enest);
    return mk(1'b0, 32'h0, 6'd0, 6'd0, 32'h0, p, 1'b1, 1'b0, 1'b0, er, erpc, ed, erem, eovf, enest);
  endfunction

  function automatic vec_t ctl(logic fl, logic ec, int ed, int erem, logic eovf, logic enest);
    return mk(1'b0, 32'h0, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0, fl, ec, 1'b0, 32'h0, ed, erem, eovf, enest);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    loop_start = 1'b0; loop_target = '0; loop_body = '0; loop_iters = '0; loop_ret = '0;
    pc = '0; pc_valid = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  // Called just after a rising edge; samples redirect mid-cycle, state after the edge.
  task automatic apply(input vec_t v);
    loop_start = v.ls; loop_target = v.tgt; loop_body = v.body; loop_iters = v.iters;
    loop_ret = v.ret; pc = v.pc; pc_valid = v.pv; flush = v.fl; err_clr = v.ec;
    @(negedge clk);
    s_a_redir = a_redirect; s_a_rpc = a_rpc; s_b_redir = b_redirect; s_b_rpc = b_rpc;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic apply_chk(input vec_t v, input string tag);
    apply(v);
    chk({tag, " redirect"}, 64'(s_a_redir), 64'(v.e_redir));
    chk({tag, " redirect_pc"}, 64'(s_a_rpc), 64'(v.e_rpc));
    chk({tag, " depth"}, 64'(a_depth), 64'(v.e_depth));
    chk({tag, " remain"}, 64'(a_remain), 64'(v.e_rem));
    chk({tag, " err_ovf"}, 64'(a_ovf), 64'(v.e_ovf));
    chk({tag, " err_nest"}, 64'(a_nest), 64'(v.e_nest));
    chk({tag, " active"}, 64'(a_active), 64'(v.e_depth != 0));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk("reset a depth", 64'(a_depth), 64'd0);
    chk("reset a redirect", 64'(a_redirect), 64'd0);
    chk("reset a redirect_pc", 64'(a_rpc), 64'd0);
    chk("reset a remain", 64'(a_remain), 64'd0);
    chk("reset a errs", 64'({a_ovf, a_nest}), 64'd0);
    chk("reset b depth", 64'(b_depth), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero-trip loop.
    tbl.push_back(jf(32'h20, 32'h80, 6'd4, 6'd0, 32'h24, 1'b1, 32'h24, 0, 0, 1'b0, 1'b0));
    // Single loop, with a pc_valid=0 hold at the end PC.
    tbl.push_back(jf(32'h0C, 32'h40, 6'd3, 6'd2, 32'h10, 1'b1, 32'h40, 1, 1, 1'b0, 1'b0));
    tbl.push_back(rt(32'h40, 1'b0, 32'h0, 1, 1, 1'b0, 1'b0));
    tbl.push_back(rt(32'h44, 1'b0, 32'h0, 1, 1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 32'h0, 6'd0, 6'd0, 32'h0, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 1, 1'b0, 1'b0));
    tbl.push_back(rt(32'h48, 1'b1, 32'h40, 1, 0, 1'b0, 1'b0));
    tbl.push_back(rt(32'h40, 1'b0, 32'h0, 1, 0, 1'b0, 1'b0));
    tbl.push_back(rt(32'h48, 1'b1, 32'h10, 0, 0, 1'b0, 1'b0));
    tbl.push_back(rt(32'h48, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0));
    // Nested: outer 0x40..0x54 x2, inner 0x44..0x48 x3, inner exit to 0x4C.
    tbl.push_back(jf(32'h0C, 32'h40, 6'd6, 6'd2, 32'h10, 1'b1, 32'h40, 1, 1, 1'b0, 1'b0));
    tbl.push_back(jf(32'h40, 32'h44, 6'd2, 6'd3, 32'h4C, 1'b1, 32'h44, 2, 2, 1'b0, 1'b0));
    tbl.push_back(rt(32'h44, 1'b0, 32'h0, 2, 2, 1'b0, 1'b0));
    tbl.push_back(rt(32'h48, 1'b1, 32'h44, 2, 1, 1'b0, 1'b0));
    tbl.push_back(rt(32'h48, 1'b1, 32'h44, 2, 0, 1'b0, 1'b0));
    tbl.push_back(rt(32'h48, 1'b1, 32'h4C, 1, 1, 1'b0, 1'b0));
    tbl.push_back(rt(32'h54, 1'b1, 32'h40, 1, 0, 1'b0, 1'b0));
    tbl.push_back(jf(32'h40, 32'h44, 6'd2, 6'd3, 32'h4C, 1'b1, 32'h44, 2, 2, 1'b0, 1'b0));
    tbl.push_back(rt(32'h48, 1'b1, 32'h44, 2, 1, 1'b0, 1'b0));
    tbl.push_back(rt(32'h48, 1'b1, 32'h44, 2, 0, 1'b0, 1'b0));
    tbl.push_back(rt(32'h48, 1'b1, 32'h4C, 1, 0, 1'b0, 1'b0));
    tbl.push_back(rt(32'h54, 1'b1, 32'h10, 0, 0, 1'b0, 1'b0));
    // Illegal nesting, misalignment, jalfor on the end PC, error-set beats clear.
    tbl.push_back(jf(32'h0C, 32'h40, 6'd6, 6'd2, 32'h10, 1'b1, 32'h40, 1, 1, 1'b0, 1'b0));
    tbl.push_back(jf(32'h40, 32'h44, 6'd5, 6'd1, 32'h60, 1'b0, 32'h0, 1, 1, 1'b0, 1'b1));
    tbl.push_back(ctl(1'b0, 1'b1, 1, 1, 1'b0, 1'b0));
    tbl.push_back(jf(32'h44, 32'h42, 6'd1, 6'd1, 32'h48, 1'b0, 32'h0, 1, 1, 1'b0, 1'b1));
    tbl.push_back(ctl(1'b0, 1'b1, 1, 1, 1'b0, 1'b0));
    tbl.push_back(jf(32'h54, 32'h44, 6'd2, 6'd1, 32'h4C, 1'b1, 32'h44, 2, 0, 1'b0, 1'b1));
    tbl.push_back(rt(32'h48, 1'b1, 32'h4C, 1, 1, 1'b0, 1'b1));
    tbl.push_back(ctl(1'b1, 1'b1, 0, 0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 32'h42, 6'd1, 6'd1, 32'h48, 32'h44, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0, 1'b0, 1'b1));
    tbl.push_back(ctl(1'b0, 1'b1, 0, 0, 1'b0, 1'b0));

    foreach (tbl[i]) apply_chk(tbl[i], $sformatf("vec%0d", i));

    // Stack full on the DEPTH=2 instance (dut a still has room).
    apply(ctl(1'b1, 1'b1, 0, 0, 1'b0, 1'b0));
    chk("full b cleared", 64'({b_depth, b_ovf, b_nest}), 64'd0);
    apply_chk(jf(32'hFC, 32'h100, 6'd16, 6'd2, 32'h200, 1'b1, 32'h100, 1, 1, 1'b0, 1'b0), "full p1");
    apply_chk(jf(32'h100, 32'h104, 6'd8, 6'd2, 32'h140, 1'b1, 32'h104, 2, 1, 1'b0, 1'b0), "full p2");
    chk("full p2 b depth", 64'(b_depth), 64'd2);
    apply_chk(jf(32'h104, 32'h108, 6'd2, 6'd2, 32'h124, 1'b1, 32'h108, 3, 1, 1'b0, 1'b0), "full p3");
    chk("full p3 b redirect", 64'(s_b_redir), 64'd0);
    chk("full p3 b depth", 64'(b_depth), 64'd2);
    chk("full p3 b err_ovf", 64'(b_ovf), 64'd1);
    chk("full p3 b err_nest", 64'(b_nest), 64'd0);
    apply(ctl(1'b0, 1'b1, 0, 0, 1'b0, 1'b0));
    chk("full clr b err_ovf", 64'(b_ovf), 64'd0);
    chk("full clr b depth", 64'(b_depth), 64'd2);
    apply_chk(ctl(1'b1, 1'b0, 0, 0, 1'b0, 1'b0), "full flush");

    // Zero-trip and pop with fall-through exit on dut b.
    apply_chk(jf(32'h20, 32'h80, 6'd4, 6'd0, 32'h24, 1'b1, 32'h24, 0, 0, 1'b0, 1'b0), "zero");
    chk("zero b redirect", 64'(s_b_redir), 64'd1);
    chk("zero b redirect_pc", 64'(s_b_rpc), 64'h90);
    chk("zero b depth", 64'(b_depth), 64'd0);
    apply_chk(jf(32'h7C, 32'h80, 6'd1, 6'd1, 32'h80, 1'b1, 32'h80, 1, 0, 1'b0, 1'b0), "ft push");
    chk("ft push b depth", 64'(b_depth), 64'd1);
    apply_chk(rt(32'h80, 1'b1, 32'h80, 0, 0, 1'b0, 1'b0), "ft pop");
    chk("ft pop b redirect", 64'(s_b_redir), 64'd0);
    chk("ft pop b redirect_pc", 64'(s_b_rpc), 64'h0);
    chk("ft pop b depth", 64'(b_depth), 64'd0);

    // Async reset mid-loop at depth 2, remain 1.
    apply_chk(jf(32'h0C, 32'h40, 6'd6, 6'd2, 32'h10, 1'b1, 32'h40, 1, 1, 1'b0, 1'b0), "rst outer");
    apply_chk(jf(32'h40, 32'h44, 6'd2, 6'd2, 32'h4C, 1'b1, 32'h44, 2, 1, 1'b0, 1'b0), "rst inner");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async depth", 64'(a_depth), 64'd0);
    chk("rst async remain", 64'(a_remain), 64'd0);
    chk("rst async active", 64'(a_active), 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_chk(rt(32'h48, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0), "rst old end");

    // Flush mid-loop, coincident with an end event.
    apply_chk(jf(32'h0C, 32'h40, 6'd6, 6'd2, 32'h10, 1'b1, 32'h40, 1, 1, 1'b0, 1'b0), "fl outer");
    apply_chk(jf(32'h40, 32'h44, 6'd2, 6'd2, 32'h4C, 1'b1, 32'h44, 2, 1, 1'b0, 1'b0), "fl inner");
    apply_chk(mk(1'b0, 32'h0, 6'd0, 6'd0, 32'h0, 32'h48, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0), "fl at end");
    apply_chk(rt(32'h48, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0), "fl old inner end");
    apply_chk(rt(32'h54, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0), "fl old outer end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
